image_stream_gen: RTL and testbench

IMAGE_STREAM_GEN -- requirements
Module: image_stream_gen

---
 rtl/image_stream_gen.sv | 256 +++++++++++++++++++++++++
 tb/tb_image_stream_gen.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_gen.sv
// Image stream generator: emits FRAME_START / ROW_START / PIXEL / ROW_END /
// FRAME_END tokens with programmable geometry, blanking and test pattern.
// Handshake: dvo is a one-cycle strobe per token with no backpressure; every
// output is registered and qualified only by dvo (all other fields are 0
// while dvo=0).

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START  4'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END    4'd2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START    4'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END      4'd4
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK   4'd8
`endif

module image_stream_gen #(
  parameter int PIXEL_WIDTH = 10,
  parameter int DIM_WIDTH   = 12
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic [DIM_WIDTH-1:0]    num_cols,
  input  logic [DIM_WIDTH-1:0]    num_rows,
  input  logic [DIM_WIDTH-1:0]    hblank,
  input  logic [DIM_WIDTH-1:0]    vblank,
  input  logic [1:0]              pattern_sel,
  output logic                    dvo,
  output logic [PIXEL_WIDTH-1:0]  ro,
  output logic [PIXEL_WIDTH-1:0]  go,
  output logic [PIXEL_WIDTH-1:0]  bo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]             meta_datao,
  output logic                    busy,
  output logic [15:0]             frame_count
);

  typedef enum logic [2:0] {
    IDLE, FSTART, RSTART, PIXEL, REND, HBLANK, FEND, VBLANK
  } state_t;

  // State register is visible hierarchically for checkers.
  state_t state_q, state_d;

  logic [DIM_WIDTH-1:0]    cols_q, cols_d, rows_q, rows_d;
  logic [DIM_WIDTH-1:0]    hblank_q, hblank_d, vblank_q, vblank_d;
  logic [1:0]              pat_q, pat_d;
  logic [DIM_WIDTH-1:0]    col_q, col_d, row_q, row_d, blank_q, blank_d;
  logic                    dvo_q, dvo_d, busy_q, busy_d;
  logic [PIXEL_WIDTH-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [`DTYPE_WIDTH-1:0] dtype_q, dtype_d;
  logic [15:0]             meta_q, meta_d, frame_count_q, frame_count_d;

  logic start_ok, row_adv, frame_adv, latch_cfg, checker_on;

  // Next-state, counters and the token for the current state (registered below).
  always_comb begin
    state_d       = state_q;
    cols_d        = cols_q;
    rows_d        = rows_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    pat_d         = pat_q;
    col_d         = col_q;
    row_d         = row_q;
    blank_d       = blank_q;
    dvo_d         = 1'b0;
    dtype_d       = '0;
    meta_d        = '0;
    r_d           = '0;
    g_d           = '0;
    b_d           = '0;
    frame_count_d = frame_count_q;
    busy_d        = (state_q != IDLE);
    start_ok      = enable && (num_rows != '0) && (num_cols != '0);
    row_adv       = 1'b0;
    frame_adv     = 1'b0;
    latch_cfg     = 1'b0;
    checker_on    = |((col_q ^ row_q) & DIM_WIDTH'(8));

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d   = FSTART;
          latch_cfg = 1'b1;
        end
      end
      FSTART: begin
        dvo_d   = 1'b1;
        dtype_d = `DTYPE_FRAME_START;
        meta_d  = frame_count_q;
        row_d   = '0;
        col_d   = '0;
        state_d = RSTART;
      end
      RSTART: begin
        dvo_d   = 1'b1;
        dtype_d = `DTYPE_ROW_START;
        meta_d  = 16'(row_q);
        col_d   = '0;
        state_d = PIXEL;
      end
      PIXEL: begin
        dvo_d   = 1'b1;
        dtype_d = `DTYPE_PIXEL_MASK;
        case (pat_q)
          2'd0: begin
            r_d = PIXEL_WIDTH'(col_q);
            g_d = PIXEL_WIDTH'(col_q);
            b_d = PIXEL_WIDTH'(col_q);
          end
          2'd1: begin
            r_d = PIXEL_WIDTH'(row_q);
            g_d = PIXEL_WIDTH'(row_q);
            b_d = PIXEL_WIDTH'(row_q);
          end
          2'd2: begin
            r_d = PIXEL_WIDTH'(col_q);
            g_d = PIXEL_WIDTH'(row_q);
            b_d = PIXEL_WIDTH'(frame_count_q);
          end
          default: begin
            r_d = {PIXEL_WIDTH{checker_on}};
            g_d = {PIXEL_WIDTH{checker_on}};
            b_d = {PIXEL_WIDTH{checker_on}};
          end
        endcase
        // Compare against cols-1 so a full-scale column count never overflows.
        if (col_q == cols_q - DIM_WIDTH'(1)) begin
          col_d   = '0;
          state_d = REND;
        end else begin
          col_d = col_q + DIM_WIDTH'(1);
        end
      end
      REND: begin
        dvo_d   = 1'b1;
        dtype_d = `DTYPE_ROW_END;
        if (hblank_q != '0) begin
          blank_d = '0;
          state_d = HBLANK;
        end else begin
          row_adv = 1'b1;
        end
      end
      HBLANK: begin
        if (blank_q == hblank_q - DIM_WIDTH'(1)) row_adv = 1'b1;
        else blank_d = blank_q + DIM_WIDTH'(1);
      end
      FEND: begin
        dvo_d         = 1'b1;
        dtype_d       = `DTYPE_FRAME_END;
        frame_count_d = frame_count_q + 16'd1;
        if (vblank_q != '0) begin
          blank_d = '0;
          state_d = VBLANK;
        end else begin
          frame_adv = 1'b1;
        end
      end
      VBLANK: begin
        if (blank_q == vblank_q - DIM_WIDTH'(1)) frame_adv = 1'b1;
        else blank_d = blank_q + DIM_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase

    if (row_adv) begin
      if (row_q == rows_q - DIM_WIDTH'(1)) begin
        state_d = FEND;
      end else begin
        row_d   = row_q + DIM_WIDTH'(1);
        state_d = RSTART;
      end
    end

    if (frame_adv) begin
      if (start_ok) begin
        state_d   = FSTART;
        latch_cfg = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    // Geometry is captured only when a new frame is committed.
    if (latch_cfg) begin
      cols_d   = num_cols;
      rows_d   = num_rows;
      hblank_d = hblank;
      vblank_d = vblank;
      pat_d    = pattern_sel;
    end
  end

  // State, configuration, counters and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q       <= IDLE;
      cols_q        <= '0;
      rows_q        <= '0;
      hblank_q      <= '0;
      vblank_q      <= '0;
      pat_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      blank_q       <= '0;
      dvo_q         <= 1'b0;
      dtype_q       <= '0;
      meta_q        <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cols_q        <= cols_d;
      rows_q        <= rows_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      pat_q         <= pat_d;
      col_q         <= col_d;
      row_q         <= row_d;
      blank_q       <= blank_d;
      dvo_q         <= dvo_d;
      dtype_q       <= dtype_d;
      meta_q        <= meta_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign dvo         = dvo_q;
  assign ro          = r_q;
  assign go          = g_q;
  assign bo          = b_q;
  assign dtypeo      = dtype_q;
  assign meta_datao  = meta_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_image_stream_gen.sv
// Bench for image_stream_gen: frame plans are expanded into an expected token
// queue by a reference model; a negedge monitor pops and compares tokens and
// the idle-cycle gap preceding each one.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START  4'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END    4'd2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START    4'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END      4'd4
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK   4'd8
`endif

module tb_image_stream_gen;
  localparam int PW = 10;
  localparam int DW = 12;
  localparam int EW = 3 * PW + 52;
  localparam int BUDGET = 20000;

  typedef struct {
    int cols;
    int rows;
    int hb;
    int vb;
    int pat;
  } cfg_t;

  logic                    clk = 1'b0;
  logic                    resetb = 1'b0;
  logic                    enable = 1'b0;
  logic [DW-1:0]           num_cols = '0, num_rows = '0, hblank = '0, vblank = '0;
  logic [1:0]              pattern_sel = '0;
  logic                    dvo, busy;
  logic [PW-1:0]           ro, go, bo;
  logic [`DTYPE_WIDTH-1:0] dtypeo;
  logic [15:0]             meta_datao, frame_count;

  int compared = 0;
  int mismatched = 0;
  logic [EW-1:0] exp_q[$];
  int fs_seen = 0;
  int model_fc = 0;
  int gap_cnt = 0;
  logic [EW-1:0] mon_e;
  logic [EW-33:0] mon_act;
  cfg_t plan[$];

  image_stream_gen #(.PIXEL_WIDTH(PW), .DIM_WIDTH(DW)) dut (
    .clk(clk), .resetb(resetb), .enable(enable),
    .num_cols(num_cols), .num_rows(num_rows), .hblank(hblank), .vblank(vblank),
    .pattern_sel(pattern_sel), .dvo(dvo), .ro(ro), .go(go), .bo(bo),
    .dtypeo(dtypeo), .meta_datao(meta_datao), .busy(busy), .frame_count(frame_count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  task automatic push_tok(input int gap, input int dt, input int meta,
                          input int rv, input int gv, input int bv);
    exp_q.push_back({32'(gap), 4'(dt), 16'(meta), PW'(rv), PW'(gv), PW'(bv)});
  endtask

  task automatic push_frame(input cfg_t c, input int fs_gap);
    int mask;
    int rv, gv, bv;
    mask = (1 << PW) - 1;
    push_tok(fs_gap, `DTYPE_FRAME_START, model_fc, 0, 0, 0);
    for (int r = 0; r < c.rows; r++) begin
      push_tok((r == 0) ? 0 : c.hb, `DTYPE_ROW_START, r, 0, 0, 0);
      for (int x = 0; x < c.cols; x++) begin
        case (c.pat)
          0: begin rv = x & mask; gv = rv; bv = rv; end
          1: begin rv = r & mask; gv = rv; bv = rv; end
          2: begin rv = x & mask; gv = r & mask; bv = model_fc & mask; end
          default: begin
            rv = ((((x >> 3) ^ (r >> 3)) & 1) != 0) ? mask : 0;
            gv = rv; bv = rv;
          end
        endcase
        push_tok(0, `DTYPE_PIXEL_MASK, 0, rv, gv, bv);
      end
      push_tok(0, `DTYPE_ROW_END, 0, 0, 0, 0);
    end
    push_tok(c.hb, `DTYPE_FRAME_END, 0, 0, 0, 0);
    model_fc = (model_fc + 1) & 16'hFFFF;
  endtask

  // Driver tasks
  task automatic drive_cfg(input cfg_t c);
    num_cols    = DW'(c.cols);
    num_rows    = DW'(c.rows);
    hblank      = DW'(c.hb);
    vblank      = DW'(c.vb);
    pattern_sel = 2'(c.pat);
  endtask

  task automatic scramble_cfg();
    num_cols    = DW'($urandom_range(0, 30));
    num_rows    = DW'($urandom_range(0, 9));
    hblank      = DW'($urandom_range(0, 7));
    vblank      = DW'($urandom_range(0, 7));
    pattern_sel = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_fs(input int target, input string name);
    for (int t = 0; t < BUDGET; t++) begin
      if (fs_seen >= target) break;
      @(negedge clk);
    end
    chk(name, 32'(fs_seen >= target), 32'd1);
  endtask

  // Runs every frame in plan back to back, with mid-frame config changes for
  // the following frame, and drops enable during the last one.
  task automatic run_plan(input string name);
    int base, n, flen, d;
    bit done;
    n = plan.size();
    base = fs_seen;
    @(negedge clk);
    drive_cfg(plan[0]);
    enable = 1'b1;
    for (int k = 0; k < n; k++) push_frame(plan[k], (k == 0) ? -1 : plan[k - 1].vb);
    for (int k = 0; k < n; k++) begin
      wait_fs(base + k + 1, {name, "_fs_timeout"});
      if (k < n - 1) begin
        drive_cfg(plan[k + 1]);
      end else begin
        flen = 2 + plan[k].rows * (plan[k].cols + 2 + plan[k].hb) + plan[k].vb;
        d = $urandom_range(0, flen - 3);
        repeat (d) @(negedge clk);
        enable = 1'b0;
        scramble_cfg();
      end
    end
    done = 1'b0;
    for (int t = 0; t < BUDGET; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin done = 1'b1; break; end
    end
    chk({name, "_drain"}, 32'(done), 32'd1);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk({name, "_idle_dvo"}, 32'(dvo), 32'd0);
      chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    end
    chk({name, "_frame_count"}, 32'(frame_count), 32'(model_fc));
    plan.delete();
  endtask

  function automatic cfg_t mk(input int c, input int r, input int h, input int v, input int p);
    cfg_t x;
    x.cols = c; x.rows = r; x.hb = h; x.vb = v; x.pat = p;
    return x;
  endfunction

  // Scoreboard monitor: pops one expected token per dvo strobe.
  always @(negedge clk) begin
    if (!resetb) begin
      gap_cnt = 0;
    end else if (dvo) begin
      mon_act = {dtypeo, meta_datao, ro, go, bo};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_token: got %0h expected none at %0t", mon_act, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_act !== mon_e[EW-33:0]) begin
          mismatched++;
          $display("FAIL token: got %0h expected %0h at %0t", mon_act, mon_e[EW-33:0], $time);
        end
        if (mon_e[EW-1 -: 32] != 32'hFFFF_FFFF) begin
          compared++;
          if (32'(gap_cnt) != mon_e[EW-1 -: 32]) begin
            mismatched++;
            $display("FAIL gap: got %0d expected %0d at %0t", gap_cnt, mon_e[EW-1 -: 32], $time);
          end
        end
      end
      if (dtypeo == `DTYPE_FRAME_START) fs_seen++;
      gap_cnt = 0;
    end else begin
      gap_cnt++;
      compared++;
      if (dtypeo !== '0 || meta_datao !== '0 || ro !== '0 || go !== '0 || bo !== '0) begin
        mismatched++;
        $display("FAIL idle_fields: got %0h/%0h/%0h/%0h/%0h expected 0 at %0t",
                 dtypeo, meta_datao, ro, go, bo, $time);
      end
    end
  end

  initial begin
    int base, n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_dvo", 32'(dvo), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_count", 32'(frame_count), 32'd0);
    chk("reset_dtype_meta", {12'd0, dtypeo, meta_datao}, 32'd0);
    resetb = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Back-to-back small frames, no blanking
    plan.push_back(mk(4, 2, 0, 0, 0));
    plan.push_back(mk(4, 2, 0, 0, 0));
    plan.push_back(mk(4, 2, 0, 0, 0));
    run_plan("basic");

    // Blanking lengths
    plan.push_back(mk(3, 1, 2, 5, 1));
    plan.push_back(mk(3, 1, 2, 5, 1));
    run_plan("blank");

    // Enable dropped mid-frame
    plan.push_back(mk(4, 3, 1, 2, 2));
    run_plan("drop");

    // Geometry change mid-frame takes effect next frame
    plan.push_back(mk(4, 2, 0, 1, 0));
    plan.push_back(mk(8, 2, 1, 0, 3));
    run_plan("resize");

    // Zero dimensions never start a frame
    @(negedge clk);
    drive_cfg(mk(5, 0, 0, 0, 0));
    enable = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      chk("zero_rows_dvo", 32'(dvo), 32'd0);
      chk("zero_rows_busy", 32'(busy), 32'd0);
    end
    drive_cfg(mk(0, 3, 0, 0, 0));
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      chk("zero_cols_busy", 32'(busy), 32'd0);
    end
    enable = 1'b0;

    // Randomized plans
    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        plan.push_back(mk($urandom_range(1, 20), $urandom_range(1, 5),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
      run_plan("random");
    end

    // Full-scale dimensions, index wrap into pixel width
    plan.push_back(mk(4095, 1, 0, 0, 2));
    run_plan("max_cols");
    plan.push_back(mk(1, 4095, 0, 1, 1));
    run_plan("max_rows");

    // Reset in the middle of frame 3
    model_fc = 0;
    resetb = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    exp_q.delete();
    base = fs_seen;
    @(negedge clk);
    drive_cfg(mk(6, 4, 1, 1, 0));
    enable = 1'b1;
    for (int k = 0; k < 5; k++) push_frame(mk(6, 4, 1, 1, 0), (k == 0) ? -1 : 1);
    wait_fs(base + 3, "abort_fs_timeout");
    repeat (3) @(negedge clk);
    #3 resetb = 1'b0;
    #1;
    chk("abort_dvo", 32'(dvo), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_frame_count", 32'(frame_count), 32'd0);
    chk("abort_pixels", {2'd0, ro, go, bo}, 32'd0);
    chk("abort_dtype_meta", {12'd0, dtypeo, meta_datao}, 32'd0);
    exp_q.delete();
    model_fc = 0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    chk("abort_release_fc", 32'(frame_count), 32'd0);
    plan.push_back(mk(2, 2, 0, 0, 2));
    run_plan("after_abort");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
